aig_resp_compactor: RTL and testbench
=====================================

Name:
aig_resp_compactor

Overview:
- Downstream capture stage for the generated combinational benchmark netlists (25 inputs x0..x24, 22 outputs f1..f22).
- Consumes one benchmark output vector per accepted beat and folds it into a multiple-input signature register (MISR).
- Counts accepted vectors and reports the final signature when a run completes.
- Lets a dataset run check a balanced or optimised netlist against its original with one signature compare.

Parameters:
- OUT_W, 22, width of the benchmark output vector (f1 in bit 0 .. f22 in bit 21).
- SIG_W, 32, signature width; elaboration error if OUT_W > SIG_W.
- POLY, 32'h04C11DB7, MISR feedback polynomial; only the low SIG_W bits are used.
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on start.
- CNT_W, 16, width of the vector count and the vector counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse that begins a run; sampled only in IDLE or DONE.
- num_vec  in  CNT_W  number of vectors in the run; sampled when start is accepted.
- in_valid  in  1  resp is valid this cycle.
- in_ready  out  1  block accepts resp this cycle.
- resp  in  OUT_W  benchmark output vector.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- vec_cnt  out  CNT_W  number of vectors accepted in the current run.
- signature  out  SIG_W  current MISR value.

Behaviour:
- Reset (clock edge with rst_n=0):
  - state=IDLE, signature=SEED, vec_cnt=0, busy=0, done=0, in_ready=0.
  - Reset in the middle of a run discards the run completely; the next cycle is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and num_vec!=0 -> RUN. The same edge loads signature=SEED, vec_cnt=0 and latches num_vec.
  - start=1 and num_vec==0 -> DONE. The same edge loads signature=SEED and vec_cnt=0.
- RUN:
  - in_ready=1 (registered state decode, does not depend on in_valid).
  - Accept when in_valid & in_ready.
  - On accept: vec_cnt+=1 and signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp.
  - Signature and vec_cnt are visible one cycle after the accepting edge.
  - The accept that makes vec_cnt equal to the latched num_vec -> DONE on the same edge.
  - start is ignored in RUN.
  - in_valid=0 holds all state; there is no timeout.
- DONE:
  - done=1 and in_ready=0; signature and vec_cnt are held.
  - start behaves exactly as in IDLE, so back-to-back runs need no return to IDLE.
- Handshake: resp must stay stable while in_valid=1 and in_ready=0. While in_ready=0 the block ignores resp.
- vec_cnt never wraps, because a run ends at num_vec <= 2^CNT_W-1.
- done and busy are mutually exclusive; both are 0 in IDLE.

Optional Feature:
- Macro: AIG_RESP_GOLDEN_CMP_EN.
- When defined, these ports are added:
  - golden  in  OUT_W  expected vector, qualified by the same handshake as resp.
  - err_cnt  out  CNT_W  number of accepted beats with resp != golden; cleared on reset and on start; saturates at all-ones.
  - first_err_idx  out  CNT_W  value of vec_cnt before the first mismatching beat; all-ones when there has been no mismatch.
  - err_cnt and first_err_idx update on the same edge as signature.
- When undefined, these ports and their logic are absent. Signature behaviour is identical in both builds.

Test Plan:
- Reset, then start with num_vec=1, then accept resp=0 -> signature=32'hFB3EE249, vec_cnt=1, done=1 the cycle after the accept.
- Start with num_vec=2 and accept resp=0 then resp=22'h3FFFFF -> signature=32'hF28326DA, done=1, in_ready=0 afterwards.
- num_vec=2 with in_valid toggling 1,0,0,1 -> only 2 accepts, same signature as the previous scenario; start pulsed during RUN is ignored.
- start with num_vec=0 -> DONE the next cycle, signature=32'hFFFFFFFF, vec_cnt=0.
- rst_n=0 after 1 of 3 vectors has been accepted -> next cycle IDLE, signature=SEED, vec_cnt=0, in_ready=0; a new start works normally.
- AIG_RESP_GOLDEN_CMP_EN defined, 4 vectors, mismatches at indices 1 and 3 -> err_cnt=2, first_err_idx=1; a start with no mismatches gives err_cnt=0 and first_err_idx=16'hFFFF.

Source files
------------

// File: rtl/aig_resp_compactor.sv
// Response compactor: folds benchmark output vectors into a MISR signature and counts them.
// Optional macro AIG_RESP_GOLDEN_CMP_EN adds a per-beat compare against a golden vector stream.
module aig_resp_compactor #(
  parameter int          OUT_W = 22,
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] resp,
`ifdef AIG_RESP_GOLDEN_CMP_EN
  input  logic [OUT_W-1:0] golden,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [SIG_W-1:0] signature
);

  generate
    if (OUT_W > SIG_W) begin : g_width_check
      $error("aig_resp_compactor: OUT_W must not exceed SIG_W");
    end
  endgenerate

  localparam logic [SIG_W-1:0] POLY_S = SIG_W'(POLY);
  localparam logic [SIG_W-1:0] SEED_S = SIG_W'(SEED);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             accept;
  logic             start_ok;
  logic [SIG_W-1:0] sig_step;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    accept   = (state_q == ST_RUN) && in_valid;
    start_ok = (state_q != ST_RUN) && start;
    sig_step = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY_S : '0)
             ^ SIG_W'(resp);
    cnt_inc  = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_d   = SEED_S;
          cnt_d   = '0;
          num_d   = num_vec;
          state_d = (num_vec != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          // Finishing beat leaves RUN on the same edge it is absorbed.
          if (cnt_inc == num_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED_S;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    vec_cnt   = cnt_q;
    signature = sig_q;
  end

`ifdef AIG_RESP_GOLDEN_CMP_EN
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             miscompare;

  always_comb begin
    miscompare = accept && (resp != golden);
    err_d      = err_q;
    first_d    = first_q;
    if (start_ok) begin
      err_d   = '0;
      first_d = '1;
    end else if (miscompare) begin
      // An all-ones index can never be a real pre-beat count, so it marks "no error yet".
      if (err_q == '0) first_d = cnt_q;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q   <= '0;
      first_q <= '1;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    err_cnt       = err_q;
    first_err_idx = first_q;
  end
`endif

endmodule

// File: tb/tb_aig_resp_compactor.sv
// Self-checking bench for aig_resp_compactor: directed test-plan scenarios plus randomized runs
// against a transaction-level reference model. Define AIG_RESP_GOLDEN_CMP_EN to cover the compare ports.
module tb_aig_resp_compactor;
  localparam int OUT_W = 22;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] resp;
  logic [OUT_W-1:0] golden;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;
  logic [SIG_W-1:0] signature;
`ifdef AIG_RESP_GOLDEN_CMP_EN
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
`endif

  aig_resp_compactor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready), .resp(resp),
`ifdef AIG_RESP_GOLDEN_CMP_EN
    .golden(golden), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
`endif
    .busy(busy), .done(done), .vec_cnt(vec_cnt), .signature(signature)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = idle, 1 = running, 2 = finished
  int          m_mode;
  logic [31:0] m_sig;
  int          m_cnt;
  int          m_num;
  int          m_err;
  int          m_first;

  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [21:0] r);
    longint unsigned v;
    v = (longint'(s) * 2) % 64'h1_0000_0000;
    if (s >= 32'h8000_0000) v = v ^ longint'(POLY);
    v = v ^ longint'(r);
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", 64'(busy), 64'(m_mode == 1));
    chk("done", 64'(done), 64'(m_mode == 2));
    chk("in_ready", 64'(in_ready), 64'(m_mode == 1));
    chk("vec_cnt", 64'(vec_cnt), 64'(m_cnt));
    chk("signature", 64'(signature), 64'(m_sig));
`ifdef AIG_RESP_GOLDEN_CMP_EN
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("first_err_idx", 64'(first_err_idx), 64'(m_first));
`endif
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare after the edge.
  task automatic cycle(input bit st, input int num, input bit v, input logic [21:0] r,
                       input logic [21:0] g);
    start = st; num_vec = CNT_W'(num); in_valid = v; resp = r; golden = g;
    if (!rst_n) begin
      m_mode = 0; m_sig = SEED; m_cnt = 0; m_err = 0; m_first = 65535;
    end else if (m_mode != 1 && st) begin
      m_sig = SEED; m_cnt = 0; m_num = num; m_err = 0; m_first = 65535;
      m_mode = (num != 0) ? 1 : 2;
    end else if (m_mode == 1 && v) begin
      if (r != g) begin
        if (m_err == 0) m_first = m_cnt;
        if (m_err < 65535) m_err++;
      end
      m_sig = misr_next(m_sig, r);
      m_cnt++;
      if (m_cnt == m_num) m_mode = 2;
    end
    @(posedge clk);
    #1;
    $display("cyc st=%0d num=%0d v=%0d resp=%06h -> busy=%0d done=%0d cnt=%0d sig=%08h",
             st, num, v, r, busy, done, vec_cnt, signature);
    check_all();
    start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [21:0] r, g;
    rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0; resp = '0; golden = '0;
    m_num = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 22'h12345, 0);
    rst_n = 1'b1;
    cycle(0, 0, 1, 22'h1, 22'h1);

    // Single vector of zeros
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("tp1_sig", 64'(signature), 64'h0000_0000_FB3E_E249);
    chk("tp1_cnt", 64'(vec_cnt), 64'd1);
    chk("tp1_done", 64'(done), 64'd1);

    // Two vectors back-to-back from DONE
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 22'h3FFFFF, 22'h3FFFFF);
    chk("tp2_sig", 64'(signature), 64'h0000_0000_F283_26DA);
    chk("tp2_ready", 64'(in_ready), 64'd0);
    cycle(0, 0, 1, 22'h155555, 0);
    chk("tp2_hold", 64'(signature), 64'h0000_0000_F283_26DA);

    // Gapped valid with a start pulse during RUN
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 5, 0, 22'h2AAAAA, 0);
    cycle(0, 0, 0, 22'h111111, 0);
    cycle(0, 0, 1, 22'h3FFFFF, 22'h3FFFFF);
    chk("tp3_sig", 64'(signature), 64'h0000_0000_F283_26DA);
    chk("tp3_cnt", 64'(vec_cnt), 64'd2);

    // Zero-length run
    cycle(1, 0, 0, 0, 0);
    chk("tp4_done", 64'(done), 64'd1);
    chk("tp4_sig", 64'(signature), 64'h0000_0000_FFFF_FFFF);

    // Reset mid-run
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 1, 22'h0ABCDE, 22'h0ABCDE);
    rst_n = 1'b0;
    cycle(0, 0, 1, 22'h3, 22'h3);
    rst_n = 1'b1;
    chk("tp5_ready", 64'(in_ready), 64'd0);
    chk("tp5_sig", 64'(signature), 64'(SEED));
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("tp5_restart", 64'(signature), 64'h0000_0000_FB3E_E249);

`ifdef AIG_RESP_GOLDEN_CMP_EN
    cycle(1, 4, 0, 0, 0);
    cycle(0, 0, 1, 22'h000010, 22'h000010);
    cycle(0, 0, 1, 22'h000020, 22'h000021);
    cycle(0, 0, 1, 22'h000030, 22'h000030);
    cycle(0, 0, 1, 22'h000040, 22'h100040);
    chk("tp6_err", 64'(err_cnt), 64'd2);
    chk("tp6_first", 64'(first_err_idx), 64'd1);
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 22'h7, 22'h7);
    cycle(0, 0, 1, 22'h9, 22'h9);
    chk("tp6_clean_err", 64'(err_cnt), 64'd0);
    chk("tp6_clean_first", 64'(first_err_idx), 64'hFFFF);
`endif

    // Randomized runs
    for (int i = 0; i < 400; i++) begin
      r = 22'($urandom);
      g = ($urandom_range(0, 3) == 0) ? (r ^ 22'($urandom_range(1, 22'h3FFFFF))) : r;
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        cycle(0, 0, 1, r, g);
        rst_n = 1'b1;
      end else if (m_mode != 1) begin
        cycle($urandom_range(0, 2) != 0, $urandom_range(0, 6), 1'($urandom), r, g);
      end else begin
        cycle($urandom_range(0, 4) == 0, $urandom_range(0, 6), $urandom_range(0, 2) != 0, r, g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
